// File: rtl/mdr_mem_interface.sv
// Memory data register and single-outstanding memory request sequencer (IDLE/REQ/DONE).
// Optional REQ timeout watchdog enabled by defining MDR_TIMEOUT_EN.
module mdr_mem_interface #(
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              in_clk,
    input  logic              in_clr,
    input  logic              in_read_start,
    input  logic              in_write_start,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [3:0]        in_dest,
    input  logic              in_mdr_in,
    input  logic [31:0]       in_bus_data,
    output logic              out_mem_req,
    output logic              out_mem_we,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic [31:0]       out_mem_wdata,
    input  logic              in_mem_ack,
    input  logic [31:0]       in_mem_rdata,
    output logic [31:0]       out_mdr,
    output logic              out_rf_write,
    output logic [3:0]        out_rf_select,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_timeout
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        dest_q;
    logic              is_read_q;
    logic [31:0]       mdr_q;
    logic              timed_out;
    logic              start;

    assign start = in_read_start | in_write_start;

`ifdef MDR_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic       timeout_q;
    logic       expire;

    assign expire    = (state_q == StReq) && !in_mem_ack && (cnt_q == TimeoutLast);
    assign timed_out = timeout_q;

    always_ff @(posedge in_clk or posedge in_clr) begin
        if (in_clr) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (expire) begin
            timeout_q <= 1'b1;
        end else if (state_q == StReq && !in_mem_ack) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
`else
    logic expire;

    assign expire    = 1'b0;
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = StReq;
            StReq:  if (in_mem_ack || expire) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_clr) begin
        if (in_clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Read wins when both starts are high; mdr_in only loads when no start is present.
    always_ff @(posedge in_clk or posedge in_clr) begin
        if (in_clr) begin
            addr_q    <= '0;
            dest_q    <= '0;
            is_read_q <= 1'b0;
            mdr_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q    <= in_addr;
                        dest_q    <= in_dest;
                        is_read_q <= in_read_start;
                    end else if (in_mdr_in) begin
                        mdr_q <= in_bus_data;
                    end
                end
                StReq: begin
                    if (in_mem_ack && is_read_q) begin
                        mdr_q <= in_mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_mem_req   = (state_q == StReq);
        out_mem_we    = (state_q == StReq) && !is_read_q;
        out_mem_addr  = addr_q;
        out_mem_wdata = mdr_q;
        out_mdr       = mdr_q;
        out_busy      = (state_q != StIdle);
        out_done      = (state_q == StDone);
        out_rf_write  = (state_q == StDone) && is_read_q && !timed_out;
        out_rf_select = out_rf_write ? dest_q : 4'd0;
        out_timeout   = (state_q == StDone) && timed_out;
    end

endmodule

// File: tb/tb_mdr_mem_interface.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mdr_mem_interface;

    localparam int unsigned AW = 9;
    localparam int unsigned TO = 4;
`ifdef MDR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          rs = 1'b0, ws = 1'b0, mi = 1'b0, ack = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [3:0]    dest = '0;
    logic [31:0]   bus = '0, rdata = '0;

    logic          mem_req, mem_we, rf_write, busy, done, tmo;
    logic [AW-1:0] mem_addr;
    logic [31:0]   wdata, mdr;
    logic [3:0]    rf_sel;

    int checks = 0;
    int errors = 0;

    mdr_mem_interface #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .in_clk(clk), .in_clr(clr), .in_read_start(rs), .in_write_start(ws),
        .in_addr(addr), .in_dest(dest), .in_mdr_in(mi), .in_bus_data(bus),
        .out_mem_req(mem_req), .out_mem_we(mem_we), .out_mem_addr(mem_addr),
        .out_mem_wdata(wdata), .in_mem_ack(ack), .in_mem_rdata(rdata),
        .out_mdr(mdr), .out_rf_write(rf_write), .out_rf_select(rf_sel),
        .out_busy(busy), .out_done(done), .out_timeout(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding access, tracked by how long it has waited.
    bit            m_in_flight, m_finished, m_read, m_to;
    int            m_wait;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_dest;
    logic [31:0]   m_mdr;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_in_flight = 0; m_finished = 0; m_read = 0; m_to = 0; m_wait = 0;
            m_addr = '0; m_dest = '0; m_mdr = '0;
        end else if (m_finished) begin
            m_finished = 0;
        end else if (m_in_flight) begin
            m_wait = m_wait + 1;
            if (ack) begin
                if (m_read) m_mdr = rdata;
                m_in_flight = 0; m_finished = 1; m_to = 0;
            end else if (TO_EN && m_wait == TO) begin
                m_in_flight = 0; m_finished = 1; m_to = 1;
            end
        end else if (rs || ws) begin
            m_in_flight = 1; m_read = rs; m_addr = addr; m_dest = dest; m_wait = 0; m_to = 0;
        end else if (mi) begin
            m_mdr = bus;
        end
    end

    always @(negedge clk) begin
        if (!clr) begin
            automatic bit exp_rfw = m_finished && m_read && !m_to;
            chk("mem_req", 32'(mem_req), 32'(m_in_flight));
            chk("mem_we", 32'(mem_we), 32'(m_in_flight && !m_read));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", wdata, m_mdr);
            chk("mdr", mdr, m_mdr);
            chk("busy", 32'(busy), 32'(m_in_flight || m_finished));
            chk("done", 32'(done), 32'(m_finished));
            chk("rf_write", 32'(rf_write), 32'(exp_rfw));
            chk("rf_select", 32'(rf_sel), exp_rfw ? 32'(m_dest) : 32'd0);
            chk("timeout", 32'(tmo), 32'(m_finished && m_to));
        end
    end

    task automatic step(input logic r, input logic w, input logic [AW-1:0] a, input logic [3:0] d,
                        input logic m, input logic [31:0] b, input logic k, input logic [31:0] rd);
        @(posedge clk);
        #1;
        rs = r; ws = w; addr = a; dest = d; mi = m; bus = b; ack = k; rdata = rd;
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, '0, 0, '0);
    endtask

    initial begin
        int done_cnt;
        #12 clr = 1'b0;
        #1;
        chk("reset_mdr", mdr, 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req", 32'(mem_req), 32'd0);

        // Read with ack in the first REQ cycle.
        step(1, 0, 9'h010, 4'd5, 0, '0, 0, '0);
        step(0, 0, '0, '0, 0, '0, 1, 32'h12345678);
        @(negedge clk); #1;
        chk("rd_req", 32'(mem_req), 32'd1);
        chk("rd_addr", 32'(mem_addr), 32'h010);
        chk("rd_we", 32'(mem_we), 32'd0);
        idle();
        @(negedge clk); #1;
        chk("rd_done", 32'(done), 32'd1);
        chk("rd_mdr", mdr, 32'h12345678);
        chk("rd_rfw", 32'(rf_write), 32'd1);
        chk("rd_rfsel", 32'(rf_sel), 32'd5);
        idle();
        @(negedge clk); #1;
        chk("rd_rfw_gone", 32'(rf_write), 32'd0);
        chk("rd_done_gone", 32'(done), 32'd0);

        // mdr_in load then write held for 3 REQ cycles.
        step(0, 0, '0, '0, 1, 32'hCAFEF00D, 0, '0);
        step(0, 1, 9'h1FF, 4'd3, 0, '0, 0, '0);
        idle();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) step(0, 0, '0, '0, 0, '0, 1, 32'hDEADBEEF);
            else if (i == 1) idle();
            @(negedge clk); #1;
            chk("wr_we", 32'(mem_we), 32'd1);
            chk("wr_wdata", wdata, 32'hCAFEF00D);
            chk("wr_addr", 32'(mem_addr), 32'h1FF);
        end
        idle();
        @(negedge clk); #1;
        chk("wr_done", 32'(done), 32'd1);
        chk("wr_rfw", 32'(rf_write), 32'd0);
        chk("wr_mdr", mdr, 32'hCAFEF00D);

        // Both starts together, then a stray start during REQ.
        step(1, 1, 9'h0AA, 4'd9, 0, '0, 0, '0);
        step(0, 1, 9'h055, 4'd2, 0, '0, 0, '0);
        @(negedge clk); #1;
        chk("both_we", 32'(mem_we), 32'd0);
        step(0, 0, '0, '0, 0, '0, 1, 32'h0BADF00D);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            @(negedge clk); #1;
            if (done) done_cnt++;
        end
        chk("both_one_done", 32'(done_cnt), 32'd1);
        chk("both_mdr", mdr, 32'h0BADF00D);

`ifdef MDR_TIMEOUT_EN
        step(1, 0, 9'h033, 4'd7, 0, '0, 0, '0);
        for (int i = 0; i < TO; i++) idle();
        idle();
        @(negedge clk); #1;
        chk("to_done", 32'(done), 32'd1);
        chk("to_flag", 32'(tmo), 32'd1);
        chk("to_rfw", 32'(rf_write), 32'd0);
        chk("to_mdr", mdr, 32'h0BADF00D);
        idle();
`endif

        // Asynchronous reset in the middle of REQ.
        step(1, 0, 9'h044, 4'd4, 0, '0, 0, '0);
        idle();
        @(negedge clk); #1;
        chk("ar_req_before", 32'(mem_req), 32'd1);
        clr = 1'b1;
        #1;
        chk("ar_req", 32'(mem_req), 32'd0);
        chk("ar_mdr", mdr, 32'h0);
        chk("ar_done", 32'(done), 32'd0);
        #1 clr = 1'b0;
        step(1, 0, 9'h011, 4'd6, 0, '0, 0, '0);
        step(0, 0, '0, '0, 0, '0, 1, 32'hA5A5A5A5);
        idle();
        @(negedge clk); #1;
        chk("ar_rd_rfw", 32'(rf_write), 32'd1);
        chk("ar_rd_mdr", mdr, 32'hA5A5A5A5);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, AW'($urandom),
                 4'($urandom), $urandom_range(0, 2) == 0, $urandom,
                 $urandom_range(0, 2) == 0, $urandom);
        end
        idle();
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
